// File: rtl/complex_freq_shifter.sv
// complex_freq_shifter
//   Streaming complex mixer that rotates an offset-binary I/Q stream by an
//   external NCO phasor (cos/sin). It can shift up or down, bypass or mute,
//   and the mode is selected per sample. There is a 4-stage pipeline with no
//   backpressure:
//     S1  register the converted inputs, the coefficients and the mode
//     S2  form the four partial products
//     S3  full-width sum/difference (DW+CW+1 bits, cannot overflow)
//     S4  round-half-up shift by SHIFT, then saturate to OW bits
//
// Ports
//   M100CLK             sole clock, rising edge
//   reset               asynchronous, active-high
//   in_valid            strobe qualifying i, q, cos, sin, mode
//   i, q     [DW-1:0]   offset-binary samples
//   cos, sin [CW-1:0]   two's-complement NCO outputs
//   mode     [1:0]      00 bypass, 01 up-shift, 10 down-shift, 11 mute
//   sat_clear           synchronous clear of sat_count
//   i_shifted, q_shifted [OW-1:0]  shifted samples (held between valids)
//   out_valid           qualifies i_shifted/q_shifted
//   sat_flag            current output sample saturated on either channel
//   sat_count [15:0]    saturating count of saturated output samples
module complex_freq_shifter #(
  parameter int DW    = 16,
  parameter int CW    = 17,
  parameter int OW    = 32,
  parameter int SHIFT = 0
) (
  input  logic          M100CLK,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] i,
  input  logic [DW-1:0] q,
  input  logic [CW-1:0] cos,
  input  logic [CW-1:0] sin,
  input  logic [1:0]    mode,
  input  logic          sat_clear,
  output logic [OW-1:0] i_shifted,
  output logic [OW-1:0] q_shifted,
  output logic          out_valid,
  output logic          sat_flag,
  output logic [15:0]   sat_count
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_MUTE   = 2'b11
  } mode_e;

  localparam int PW = DW + CW;          // product width
  localparam int SW = PW + 1;           // sum width, headroom for one add
  localparam int RW = SW + 1;           // room for the rounding constant
  localparam int XW = (RW > OW) ? RW : OW;

  localparam logic signed [RW-1:0] RND_HALF =
    (SHIFT > 0) ? (RW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Pipeline valid bits
  logic r1_valid, r2_valid, r3_valid;

  // S1
  logic signed [DW-1:0] r1_i, r1_q;
  logic signed [CW-1:0] r1_cos, r1_sin;
  mode_e                r1_mode;
  // S2
  logic signed [PW-1:0] r2_ic, r2_qs, r2_is, r2_qc;
  mode_e                r2_mode;
  // S3
  logic signed [SW-1:0] r3_i, r3_q;
  // S4 / outputs
  logic [OW-1:0] r_i_out, r_q_out;
  logic          r_out_valid, r_sat_flag;
  logic [15:0]   r_sat_count;

  // Operands widened to product width so that the multiply is done at full width
  logic signed [PW-1:0] w_i_ext, w_q_ext, w_cos_ext, w_sin_ext;
  assign w_i_ext   = PW'(r1_i);
  assign w_q_ext   = PW'(r1_q);
  assign w_cos_ext = PW'(r1_cos);
  assign w_sin_ext = PW'(r1_sin);

  // NOTE: Only the valid bits and the visible outputs have a reset. Datapath
  // registers are qualified by their valid bit, so their reset value is never
  // observed.
  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
    end else begin
      r1_valid <= in_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
    end
  end

  // S1: flipping the MSB turns offset binary into two's complement.
  always_ff @(posedge M100CLK) begin
    if (in_valid) begin
      r1_i    <= {~i[DW-1], i[DW-2:0]};
      r1_q    <= {~q[DW-1], q[DW-2:0]};
      r1_cos  <= cos;
      r1_sin  <= sin;
      r1_mode <= mode_e'(mode);
    end
  end

  // S2: bypass places the scaled samples in the ic/qc slots and zeros the
  // cross terms. S3 can then use the up-shift sum for bypass and for mute.
  always_ff @(posedge M100CLK) begin
    if (r1_valid) begin
      r2_mode <= r1_mode;
      case (r1_mode)
        MODE_UP, MODE_DOWN: begin
          r2_ic <= w_i_ext * w_cos_ext;
          r2_qs <= w_q_ext * w_sin_ext;
          r2_is <= w_i_ext * w_sin_ext;
          r2_qc <= w_q_ext * w_cos_ext;
        end
        MODE_BYPASS: begin
          r2_ic <= w_i_ext <<< (CW - 1);
          r2_qs <= '0;
          r2_is <= '0;
          r2_qc <= w_q_ext <<< (CW - 1);
        end
        default: begin
          r2_ic <= '0;
          r2_qs <= '0;
          r2_is <= '0;
          r2_qc <= '0;
        end
      endcase
    end
  end

  // S3: full-width sum/difference
  always_ff @(posedge M100CLK) begin
    if (r2_valid) begin
      if (r2_mode == MODE_DOWN) begin
        r3_i <= SW'(r2_ic) + SW'(r2_qs);
        r3_q <= SW'(r2_qc) - SW'(r2_is);
      end else begin
        r3_i <= SW'(r2_ic) - SW'(r2_qs);
        r3_q <= SW'(r2_is) + SW'(r2_qc);
      end
    end
  end

  // S4: round half up, arithmetic shift, then clamp. The MSB of the
  // saturated value is the saturation flag.
  function automatic logic [OW:0] round_sat(input logic signed [SW-1:0] x);
    logic signed [RW-1:0] rounded;
    logic signed [XW-1:0] wide;
    rounded = (RW'(x) + RND_HALF) >>> SHIFT;
    wide    = XW'(rounded);
    if (wide > SAT_MAX)      return {1'b1, SAT_MAX[OW-1:0]};
    else if (wide < SAT_MIN) return {1'b1, SAT_MIN[OW-1:0]};
    else                     return {1'b0, wide[OW-1:0]};
  endfunction

  logic [OW:0] w_sat_i, w_sat_q;
  assign w_sat_i = round_sat(r3_i);
  assign w_sat_q = round_sat(r3_q);

  always_ff @(posedge M100CLK or posedge reset) begin
    if (reset) begin
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_sat_count <= '0;
    end else begin
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_i_out    <= w_sat_i[OW-1:0];
        r_q_out    <= w_sat_q[OW-1:0];
        r_sat_flag <= w_sat_i[OW] | w_sat_q[OW];
      end else begin
        r_sat_flag <= 1'b0;
      end
      // A saturated sample is counted in the cycle it is presented. When
      // sat_clear arrives in the same cycle, the clear wins.
      if (sat_clear)
        r_sat_count <= '0;
      else if (r_out_valid && r_sat_flag && (r_sat_count != 16'hFFFF))
        r_sat_count <= r_sat_count + 16'd1;
    end
  end

  assign i_shifted = r_i_out;
  assign q_shifted = r_q_out;
  assign out_valid = r_out_valid;
  assign sat_flag  = r_sat_flag;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_complex_freq_shifter.sv
// Randomised plus directed bench for complex_freq_shifter at its default
// parameters (DW=16, CW=17, OW=32, SHIFT=0). The reference model works on
// plain integers: it converts offset binary by subtracting 2^15, applies the
// mixer equations, and clamps. A queue of per-cycle results stands in for
// the pipeline latency.
module tb_complex_freq_shifter;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] ti = '0, tq = '0;
  logic [16:0] tc = '0, ts = '0;
  logic [1:0]  tm = '0;
  logic        clr = 1'b0;
  logic [31:0] i_shifted, q_shifted;
  logic        out_valid, sat_flag;
  logic [15:0] sat_count;

  complex_freq_shifter dut (
    .M100CLK  (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .i        (ti),
    .q        (tq),
    .cos      (tc),
    .sin      (ts),
    .mode     (tm),
    .sat_clear(clr),
    .i_shifted(i_shifted),
    .q_shifted(q_shifted),
    .out_valid(out_valid),
    .sat_flag (sat_flag),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          v;
    logic [31:0] i;
    logic [31:0] q;
    bit          sat;
  } ent_t;

  ent_t        hist[$];
  bit          m_ov = 1'b0, m_sf = 1'b0;
  logic [31:0] m_i = '0, m_q = '0;
  int unsigned m_cnt = 0;

  function automatic logic [31:0] clamp(input longint x, output bit s);
    logic [63:0] xb;
    s = (x > MAXV) || (x < MINV);
    if (x > MAXV) return 32'h7FFF_FFFF;
    if (x < MINV) return 32'h8000_0000;
    xb = x;
    return xb[31:0];
  endfunction

  function automatic ent_t ref_model(input bit v, input logic [15:0] a, input logic [15:0] b,
                                     input logic [16:0] c, input logic [16:0] s,
                                     input logic [1:0] m);
    ent_t   e;
    longint si, sq, sc, ss, ri, rq;
    bit     s1, s2;
    si = longint'(a) - 32768;
    sq = longint'(b) - 32768;
    sc = longint'($signed(c));
    ss = longint'($signed(s));
    case (m)
      2'b00:   begin ri = si * 65536;       rq = sq * 65536;       end
      2'b01:   begin ri = si * sc - sq * ss; rq = si * ss + sq * sc; end
      2'b10:   begin ri = si * sc + sq * ss; rq = sq * sc - si * ss; end
      default: begin ri = 0;                rq = 0;                end
    endcase
    e.v   = v;
    e.i   = clamp(ri, s1);
    e.q   = clamp(rq, s2);
    e.sat = s1 | s2;
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_ov  = 1'b0;
    m_sf  = 1'b0;
    m_i   = '0;
    m_q   = '0;
    m_cnt = 0;
  endtask

  // The task is entered at a falling edge. It drives one cycle of stimulus,
  // advances the model across the rising edge and checks at the next falling edge.
  task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input logic [16:0] c, input logic [16:0] s,
                       input logic [1:0] m, input bit cl);
    ent_t e, x;
    in_valid = v; ti = a; tq = b; tc = c; ts = s; tm = m; clr = cl;
    e = ref_model(v, a, b, c, s, m);
    @(posedge clk);
    hist.push_back(e);
    if (cl) m_cnt = 0;
    else if (m_ov && m_sf && m_cnt != 32'hFFFF) m_cnt++;
    if (hist.size() == 4) begin
      x = hist.pop_front();
      m_ov = x.v;
      if (x.v) begin
        m_i  = x.i;
        m_q  = x.q;
        m_sf = x.sat;
      end else begin
        m_sf = 1'b0;
      end
    end else begin
      m_ov = 1'b0;
      m_sf = 1'b0;
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("i_shifted", i_shifted, m_i);
    check("q_shifted", q_shifted, m_q);
    check("sat_flag",  32'(sat_flag), 32'(m_sf));
    check("sat_count", 32'(sat_count), m_cnt);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cycle(1'b0, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom),
            2'($urandom), 1'b0);
  endtask

  // One sample and then three idle cycles. The sample is on the outputs at
  // the end, where it is also compared against hand-derived constants.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] c, input logic [16:0] s, input logic [1:0] m,
                          input logic [31:0] ei, input logic [31:0] eq, input bit esf);
    cycle(1'b1, a, b, c, s, m, 1'b0);
    idle(3);
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check({tag, "_i"},  i_shifted, ei);
    check({tag, "_q"},  q_shifted, eq);
    check({tag, "_sf"}, 32'(sat_flag), 32'(esf));
  endtask

  initial begin
    logic [16:0] rc, rs;

    // Power-on reset
    #1 reset = 1'b1;
    #2;
    check("rst_ov",  32'(out_valid), 32'd0);
    check("rst_i",   i_shifted, 32'd0);
    check("rst_q",   q_shifted, 32'd0);
    check("rst_sf",  32'(sat_flag), 32'd0);
    check("rst_cnt", 32'(sat_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed corners
    directed("zero_in",  16'h8000, 16'h8000, 17'h0FFFF, 17'h00000, 2'b01,
             32'h0, 32'h0, 1'b0);
    directed("full_i",   16'hFFFF, 16'h8000, 17'h0FFFF, 17'h00000, 2'b01,
             32'h7FFE8001, 32'h0, 1'b0);
    directed("sat_pos",  16'h0000, 16'h0000, 17'h10000, 17'h0FFFF, 2'b01,
             32'h7FFFFFFF, 32'h00008000, 1'b1);
    idle(1);
    check("sat_cnt_one", 32'(sat_count), 32'd1);
    // A second saturating sample with sat_clear in the cycle it is counted
    cycle(1'b1, 16'h0000, 16'h0000, 17'h10000, 17'h0FFFF, 2'b01, 1'b0);
    idle(3);
    cycle(1'b0, 16'h0, 16'h0, 17'h0, 17'h0, 2'b00, 1'b1);
    check("sat_clr_prio", 32'(sat_count), 32'd0);
    directed("down_one", 16'h8001, 16'h8000, 17'h00000, 17'h00001, 2'b10,
             32'h0, 32'hFFFFFFFF, 1'b0);
    directed("up_one",   16'h8001, 16'h8000, 17'h00000, 17'h00001, 2'b01,
             32'h0, 32'h00000001, 1'b0);
    directed("bypass",   16'h8003, 16'h7FFF, 17'h0ABCD, 17'h11234, 2'b00,
             32'h00030000, 32'hFFFF0000, 1'b0);
    directed("mute",     16'h8003, 16'h7FFF, 17'h0ABCD, 17'h11234, 2'b11,
             32'h0, 32'h0, 1'b0);

    // Random traffic with sparse valids, mixed modes and occasional clears
    for (int n = 0; n < 400; n++) begin
      rc = 17'($urandom);
      rs = 17'($urandom);
      if ($urandom_range(0, 7) == 0) rc = ($urandom_range(0, 1) != 0) ? 17'h10000 : 17'h0FFFF;
      if ($urandom_range(0, 7) == 0) rs = ($urandom_range(0, 1) != 0) ? 17'h10000 : 17'h0FFFF;
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), rc, rs,
            2'($urandom), $urandom_range(0, 15) == 0);
    end

    // Push sat_count to its ceiling and confirm that it stays there
    cycle(1'b0, 16'h0, 16'h0, 17'h0, 17'h0, 2'b00, 1'b1);
    for (int n = 0; n < 65540; n++)
      cycle(1'b1, 16'h0000, 16'h0000, 17'h10000, 17'h0FFFF, 2'b01, 1'b0);
    idle(4);
    check("sat_cnt_stick", 32'(sat_count), 32'hFFFF);

    // Burst of six samples, with reset pulsed during the second one
    cycle(1'b1, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom), 2'b01, 1'b0);
    in_valid = 1'b1; ti = 16'($urandom); tq = 16'($urandom); tm = 2'b10;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ov",  32'(out_valid), 32'd0);
    check("mid_rst_i",   i_shifted, 32'd0);
    check("mid_rst_q",   q_shifted, 32'd0);
    check("mid_rst_sf",  32'(sat_flag), 32'd0);
    check("mid_rst_cnt", 32'(sat_count), 32'd0);
    model_reset();
    @(negedge clk);
    ti = 16'($urandom); tq = 16'($urandom);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom), 2'b01, 1'b0);
    check("no_stale", 32'(out_valid), 32'd0);
    cycle(1'b1, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom), 2'b00, 1'b0);
    cycle(1'b1, 16'($urandom), 16'($urandom), 17'($urandom), 17'($urandom), 2'b10, 1'b0);
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
